// File: rtl/jtag_scan_sequencer_pkg.sv
// Shared JTAG types: TAP state encoding, scan phases, and width legality helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package jtag_scan_sequencer_pkg;

  localparam int JTAG_MAX_INSTR_WIDTH  = 5;
  localparam int JTAG_MAX_VECTOR_WIDTH = 32;

  // IEEE 1149.1 TAP controller states, using the customary 4-bit encoding
  typedef enum logic [3:0] {
    TAP_EXIT2_DR  = 4'h0,
    TAP_EXIT1_DR  = 4'h1,
    TAP_SHIFT_DR  = 4'h2,
    TAP_PAUSE_DR  = 4'h3,
    TAP_SEL_IR    = 4'h4,
    TAP_UPDATE_DR = 4'h5,
    TAP_CAPT_DR   = 4'h6,
    TAP_SEL_DR    = 4'h7,
    TAP_EXIT2_IR  = 4'h8,
    TAP_EXIT1_IR  = 4'h9,
    TAP_SHIFT_IR  = 4'hA,
    TAP_PAUSE_IR  = 4'hB,
    TAP_IDLE      = 4'hC,
    TAP_UPDATE_IR = 4'hD,
    TAP_CAPT_IR   = 4'hE,
    TAP_RESET     = 4'hF
  } tap_state_e;

  // Which part of a scan request the sequencer is currently walking
  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_TRST = 2'd1,
    PH_IR   = 2'd2,
    PH_DR   = 2'd3
  } scan_phase_e;

  // DR widths the target supports
  function automatic logic vec_width_ok(input logic [5:0] w);
    return (w == 6'd8) || (w == 6'd16) || (w == 6'd24) || (w == 6'd32);
  endfunction

  // IR widths the target supports
  function automatic logic instr_width_ok(input logic [2:0] w);
    return (w == 3'd3) || (w == 3'd4) || (w == 3'd5);
  endfunction

endpackage

// File: rtl/jtag_scan_sequencer_tracker.sv
// Mirrors the target TAP controller: IEEE 1149.1 next-state function plus state register.
// Latency: state follows tms one clk later; force_reset_i overrides tms for that edge.
// Backpressure: none, advances every clk.
module jtag_scan_sequencer_tracker
  import jtag_scan_sequencer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tms_i,
  input  logic       force_reset_i,
  output tap_state_e state_o
);

  tap_state_e state_q, state_d;

  // Standard TAP transition table, including Pause/Exit2 arcs the sequencer never uses
  always_comb begin
    state_d = state_q;
    case (state_q)
      TAP_RESET:     state_d = tms_i ? TAP_RESET     : TAP_IDLE;
      TAP_IDLE:      state_d = tms_i ? TAP_SEL_DR    : TAP_IDLE;
      TAP_SEL_DR:    state_d = tms_i ? TAP_SEL_IR    : TAP_CAPT_DR;
      TAP_CAPT_DR:   state_d = tms_i ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:  state_d = tms_i ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:  state_d = tms_i ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:  state_d = tms_i ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:  state_d = tms_i ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR: state_d = tms_i ? TAP_SEL_DR    : TAP_IDLE;
      TAP_SEL_IR:    state_d = tms_i ? TAP_RESET     : TAP_CAPT_IR;
      TAP_CAPT_IR:   state_d = tms_i ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:  state_d = tms_i ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:  state_d = tms_i ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:  state_d = tms_i ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:  state_d = tms_i ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR: state_d = tms_i ? TAP_SEL_DR    : TAP_IDLE;
      default:       state_d = TAP_RESET;
    endcase
    if (force_reset_i) begin
      state_d = TAP_RESET;
    end
  end

  // State register; async reset puts the model in Test-Logic-Reset like the target
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TAP_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/jtag_scan_sequencer.sv
// JTAG scan engine: optional TRST pulse, IR shift of an opcode, DR shift of a vector with tdo capture.
// Latency: done 10+Wir+Wdr clks after accept from Idle (+1 from Reset, +TRST_CYCLES+1 with trst).
// Backpressure: start is only accepted while busy=0 in Reset/Idle; otherwise it is ignored.
module jtag_scan_sequencer
  import jtag_scan_sequencer_pkg::*;
#(
  parameter int MAX_VECTOR_WIDTH = JTAG_MAX_VECTOR_WIDTH,
  parameter int MAX_INSTR_WIDTH  = JTAG_MAX_INSTR_WIDTH,
  parameter int TRST_CYCLES      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [5:0]                  cfgVectorWidth,
  input  logic [2:0]                  cfgInstrWidth,
  input  logic [MAX_INSTR_WIDTH-1:0]  cfgOpcode,
  input  logic                        cfgTrstEnable,
  input  logic [MAX_VECTOR_WIDTH-1:0] testVector,
  input  logic                        tdoIn,
  output logic                        tms,
  output logic                        tdi,
  output logic                        trstN,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [MAX_VECTOR_WIDTH-1:0] capturedVector,
  output logic [3:0]                  tapState
);

  localparam int CW = $clog2(MAX_VECTOR_WIDTH);
  localparam int IW = $clog2(MAX_INSTR_WIDTH);

  scan_phase_e                 phase_q;
  logic [CW-1:0]               cnt_q;
  logic [5:0]                  vw_q;
  logic [2:0]                  iw_q;
  logic [MAX_INSTR_WIDTH-1:0]  opcode_q;
  logic [MAX_VECTOR_WIDTH-1:0] vector_q;
  logic [MAX_VECTOR_WIDTH-1:0] cap_q;
  logic                        done_q;
  logic                        error_q;
  tap_state_e                  tap_q;

  logic accept;
  logic legal;
  logic ir_last;
  logic dr_last;
  logic trst_last;
  logic force_reset;

  assign busy        = (phase_q != PH_IDLE);
  assign accept      = start && !busy && ((tap_q == TAP_RESET) || (tap_q == TAP_IDLE));
  assign legal       = vec_width_ok(cfgVectorWidth) && instr_width_ok(cfgInstrWidth);
  assign ir_last     = (cnt_q == (CW'(iw_q) - CW'(1)));
  assign dr_last     = (cnt_q == CW'(vw_q - 6'd1));
  assign trst_last   = (cnt_q == CW'(TRST_CYCLES - 1));
  // Pull the model into Reset from the accept edge so it matches the target during trstN low
  assign force_reset = (accept && legal && cfgTrstEnable) || (phase_q == PH_TRST);

  jtag_scan_sequencer_tracker u_tracker (
    .clk_i         (clk),
    .rst_ni        (reset),
    .tms_i         (tms),
    .force_reset_i (force_reset),
    .state_o       (tap_q)
  );

  // tms steers the TAP along the fixed IR-then-DR path; SelectDr is visited in both phases
  always_comb begin
    tms = 1'b1;
    case (phase_q)
      PH_IDLE: tms = (tap_q == TAP_RESET);
      PH_TRST: tms = 1'b1;
      PH_IR: begin
        case (tap_q)
          TAP_RESET:     tms = 1'b0;
          TAP_IDLE:      tms = 1'b1;
          TAP_SEL_DR:    tms = 1'b1;
          TAP_SEL_IR:    tms = 1'b0;
          TAP_CAPT_IR:   tms = 1'b0;
          TAP_SHIFT_IR:  tms = ir_last;
          TAP_EXIT1_IR:  tms = 1'b1;
          TAP_UPDATE_IR: tms = 1'b1;
          default:       tms = 1'b1;
        endcase
      end
      PH_DR: begin
        case (tap_q)
          TAP_SEL_DR:    tms = 1'b0;
          TAP_CAPT_DR:   tms = 1'b0;
          TAP_SHIFT_DR:  tms = dr_last;
          TAP_EXIT1_DR:  tms = 1'b1;
          TAP_UPDATE_DR: tms = 1'b0;
          default:       tms = 1'b1;
        endcase
      end
      default: tms = 1'b1;
    endcase
  end

  // tdi carries data only in the Shift states, LSB first
  always_comb begin
    tdi = 1'b0;
    if (tap_q == TAP_SHIFT_IR) begin
      tdi = opcode_q[cnt_q[IW-1:0]];
    end else if (tap_q == TAP_SHIFT_DR) begin
      tdi = vector_q[cnt_q];
    end
  end

  // Phase FSM, bit counter, config latch and tdo capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q  <= PH_IDLE;
      cnt_q    <= '0;
      vw_q     <= '0;
      iw_q     <= '0;
      opcode_q <= '0;
      vector_q <= '0;
      cap_q    <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (phase_q)
        PH_IDLE: begin
          if (accept) begin
            if (legal) begin
              vw_q     <= cfgVectorWidth;
              iw_q     <= cfgInstrWidth;
              opcode_q <= cfgOpcode;
              vector_q <= testVector;
              cap_q    <= '0;
              cnt_q    <= '0;
              phase_q  <= cfgTrstEnable ? PH_TRST : PH_IR;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        PH_TRST: begin
          if (trst_last) begin
            cnt_q   <= '0;
            phase_q <= PH_IR;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        PH_IR: begin
          cnt_q <= (tap_q == TAP_SHIFT_IR) ? cnt_q + CW'(1) : '0;
          if (tap_q == TAP_UPDATE_IR) begin
            phase_q <= PH_DR;
          end
        end
        PH_DR: begin
          cnt_q <= (tap_q == TAP_SHIFT_DR) ? cnt_q + CW'(1) : '0;
          if (tap_q == TAP_SHIFT_DR) begin
            cap_q[cnt_q] <= tdoIn;
          end
          if (tap_q == TAP_UPDATE_DR) begin
            phase_q <= PH_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: phase_q <= PH_IDLE;
      endcase
    end
  end

  assign trstN          = (phase_q != PH_TRST);
  assign done           = done_q;
  assign error          = error_q;
  assign capturedVector = cap_q;
  assign tapState       = tap_q;

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
module tb_jtag_scan_sequencer;
  import jtag_scan_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  cfgVectorWidth;
  logic [2:0]  cfgInstrWidth;
  logic [4:0]  cfgOpcode;
  logic        cfgTrstEnable;
  logic [31:0] testVector;
  logic        tdoIn;
  logic        tms, tdi, trstN, busy, done, error;
  logic [31:0] capturedVector;
  logic [3:0]  tapState;

  int total = 0;
  int bad   = 0;

  // recorded per scan
  logic [31:0] ir_bits, dr_bits;
  int ir_n, dr_n, dr_tms0, trst_low, trst_bad;
  logic busy0;

  // target model: drives tdo on the falling edge with the tdi it sees
  logic tdo_q = 1'b0;
  logic tdo_tied = 1'b0;
  always @(negedge clk) tdo_q <= tdi;
  assign tdoIn = tdo_tied ? 1'b1 : tdo_q;

  always #5 clk = ~clk;

  jtag_scan_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .cfgVectorWidth (cfgVectorWidth),
    .cfgInstrWidth  (cfgInstrWidth),
    .cfgOpcode      (cfgOpcode),
    .cfgTrstEnable  (cfgTrstEnable),
    .testVector     (testVector),
    .tdoIn          (tdoIn),
    .tms            (tms),
    .tdi            (tdi),
    .trstN          (trstN),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .capturedVector (capturedVector),
    .tapState       (tapState)
  );

  task automatic record();
    if (tapState == TAP_SHIFT_IR) begin
      if (ir_n < 32) ir_bits[ir_n] = tdi;
      ir_n++;
    end
    if (tapState == TAP_SHIFT_DR) begin
      if (dr_n < 32) dr_bits[dr_n] = tdi;
      dr_n++;
      if (tms == 1'b0) dr_tms0++;
    end
    if (trstN == 1'b0) begin
      trst_low++;
      if (tapState != TAP_RESET) trst_bad++;
    end
  endtask

  // start must already be driven at a negedge; returns clks from accept edge to done (-1 on timeout)
  task automatic run_scan(input bit hold_in_dr, output int lat);
    ir_bits = '0; dr_bits = '0;
    ir_n = 0; dr_n = 0; dr_tms0 = 0; trst_low = 0; trst_bad = 0;
    lat = -1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    busy0 = busy;
    record();
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (hold_in_dr && tapState == TAP_SHIFT_DR) start = 1'b1;
      record();
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic set_cfg(input logic [2:0] iw, input logic [4:0] op,
                         input logic [5:0] vw, input logic [31:0] vec);
    cfgInstrWidth = iw; cfgOpcode = op; cfgVectorWidth = vw; testVector = vec;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; cfgTrstEnable = 1'b0;
    set_cfg(3'd5, 5'd0, 6'd8, 32'd0);
    @(negedge clk); @(negedge clk);
    total++; if (tapState !== TAP_RESET) begin bad++; $display("FAIL reset_tap got=%h want=%h", tapState, TAP_RESET); end
    total++; if (tms !== 1'b1) begin bad++; $display("FAIL reset_tms got=%b want=1", tms); end
    total++; if (tdi !== 1'b0) begin bad++; $display("FAIL reset_tdi got=%b want=0", tdi); end
    total++; if (trstN !== 1'b1) begin bad++; $display("FAIL reset_trstN got=%b want=1", trstN); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", error); end
    total++; if (capturedVector !== 32'd0) begin bad++; $display("FAIL reset_cap got=%h want=0", capturedVector); end
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    total++; if (tapState !== TAP_RESET || tms !== 1'b1) begin bad++; $display("FAIL reset_hold tap=%h tms=%b want=f/1", tapState, tms); end
  endtask

  task automatic test_from_reset();
    int lat;
    set_cfg(3'd5, 5'b00110, 6'd8, 32'hFFFF_FFA5);
    start = 1'b1;
    run_scan(1'b0, lat);
    total++; if (lat != 24) begin bad++; $display("FAIL from_reset_latency got=%0d want=24", lat); end
    total++; if (capturedVector !== 32'h0000_00A5) begin bad++; $display("FAIL from_reset_cap got=%h want=000000a5", capturedVector); end
    total++; if (busy !== 1'b0 || tapState !== TAP_IDLE) begin bad++; $display("FAIL from_reset_end busy=%b tap=%h want=0/c", busy, tapState); end
  endtask

  task automatic test_basic_loopback();
    int lat;
    set_cfg(3'd5, 5'b00110, 6'd8, 32'hFFFF_FFA5);
    start = 1'b1;
    run_scan(1'b0, lat);
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL basic_busy_after_accept got=%b want=1", busy0); end
    total++; if (lat != 23) begin bad++; $display("FAIL basic_latency got=%0d want=23", lat); end
    total++; if (ir_n != 5 || ir_bits[4:0] !== 5'b00110) begin bad++; $display("FAIL basic_ir n=%0d bits=%b want=5/00110", ir_n, ir_bits[4:0]); end
    total++; if (dr_n != 8 || dr_bits[7:0] !== 8'hA5) begin bad++; $display("FAIL basic_dr_tdi n=%0d bits=%h want=8/a5", dr_n, dr_bits[7:0]); end
    total++; if (capturedVector !== 32'h0000_00A5) begin bad++; $display("FAIL basic_cap got=%h want=000000a5", capturedVector); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", done); end
    total++; if (tapState !== TAP_IDLE || tms !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_idle tap=%h tms=%b busy=%b want=c/0/0", tapState, tms, busy); end
    total++; if (capturedVector !== 32'h0000_00A5) begin bad++; $display("FAIL basic_cap_held got=%h want=000000a5", capturedVector); end
  endtask

  task automatic test_tdo_ones();
    int lat;
    tdo_tied = 1'b1;
    set_cfg(3'd3, 5'b00101, 6'd32, 32'h0F0F_1234);
    start = 1'b1;
    run_scan(1'b0, lat);
    total++; if (lat != 45) begin bad++; $display("FAIL ones_latency got=%0d want=45", lat); end
    total++; if (capturedVector !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ones_cap got=%h want=ffffffff", capturedVector); end
    total++; if (dr_n != 32 || dr_tms0 != 31) begin bad++; $display("FAIL ones_shiftdr cycles=%0d tms0=%0d want=32/31", dr_n, dr_tms0); end
    total++; if (ir_n != 3 || ir_bits[2:0] !== 3'b101) begin bad++; $display("FAIL ones_ir n=%0d bits=%b want=3/101", ir_n, ir_bits[2:0]); end
    tdo_tied = 1'b0;
  endtask

  task automatic test_illegal_width();
    logic [5:0] vws [2] = '{6'd12, 6'd8};
    logic [2:0] iws [2] = '{3'd5, 3'd6};
    for (int i = 0; i < 2; i++) begin
      set_cfg(iws[i], 5'b00110, vws[i], 32'h0000_00A5);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      total++; if (error !== 1'b1 || busy !== 1'b0 || tms !== 1'b0) begin bad++; $display("FAIL illegal%0d_pulse err=%b busy=%b tms=%b want=1/0/0", i, error, busy, tms); end
      @(negedge clk);
      total++; if (error !== 1'b0 || busy !== 1'b0 || tapState !== TAP_IDLE) begin bad++; $display("FAIL illegal%0d_after err=%b busy=%b tap=%h want=0/0/c", i, error, busy, tapState); end
    end
  endtask

  task automatic test_trst();
    int lat;
    cfgTrstEnable = 1'b1;
    set_cfg(3'd5, 5'b00110, 6'd8, 32'h0000_00A5);
    start = 1'b1;
    run_scan(1'b0, lat);
    cfgTrstEnable = 1'b0;
    total++; if (trst_low != 2 || trst_bad != 0) begin bad++; $display("FAIL trst_pulse low=%0d nonreset=%0d want=2/0", trst_low, trst_bad); end
    total++; if (lat != 26) begin bad++; $display("FAIL trst_latency got=%0d want=26", lat); end
    total++; if (capturedVector !== 32'h0000_00A5) begin bad++; $display("FAIL trst_cap got=%h want=000000a5", capturedVector); end
  endtask

  task automatic test_back_to_back();
    int lat;
    set_cfg(3'd5, 5'b00110, 6'd8, 32'h0000_003C);
    start = 1'b1;
    run_scan(1'b1, lat);
    total++; if (lat != 23) begin bad++; $display("FAIL b2b_first_latency got=%0d want=23", lat); end
    total++; if (capturedVector !== 32'h0000_003C) begin bad++; $display("FAIL b2b_first_cap got=%h want=0000003c", capturedVector); end
    total++; if (busy !== 1'b0 || start !== 1'b1) begin bad++; $display("FAIL b2b_done_cycle busy=%b start=%b want=0/1", busy, start); end
    // start is still high on the done cycle: the next edge accepts the new config
    set_cfg(3'd3, 5'b00011, 6'd16, 32'hABCD_BEEF);
    run_scan(1'b0, lat);
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL b2b_second_accept busy=%b want=1", busy0); end
    total++; if (lat != 29) begin bad++; $display("FAIL b2b_second_latency got=%0d want=29", lat); end
    total++; if (capturedVector !== 32'h0000_BEEF) begin bad++; $display("FAIL b2b_second_cap got=%h want=0000beef", capturedVector); end
  endtask

  task automatic test_reset_mid_scan(input logic [3:0] where, input int extra);
    bit found = 1'b0;
    set_cfg(3'd5, 5'b00110, 6'd8, 32'h0000_00FF);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (tapState == where) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++; if (!found) begin bad++; $display("FAIL midreset_%h_reach tap=%h want=%h", where, tapState, where); end
    for (int k = 0; k < extra; k++) @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (tms !== 1'b1 || busy !== 1'b0 || tapState !== TAP_RESET) begin bad++; $display("FAIL midreset_%h_now tms=%b busy=%b tap=%h want=1/0/f", where, tms, busy, tapState); end
    total++; if (capturedVector !== 32'd0 || tdi !== 1'b0 || trstN !== 1'b1) begin bad++; $display("FAIL midreset_%h_outs cap=%h tdi=%b trstN=%b want=0/0/1", where, capturedVector, tdi, trstN); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (tapState !== TAP_RESET || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midreset_%h_after tap=%h busy=%b done=%b want=f/0/0", where, tapState, busy, done); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_from_reset();
    test_basic_loopback();
    test_tdo_ones();
    test_illegal_width();
    test_trst();
    test_back_to_back();
    test_reset_mid_scan(TAP_SHIFT_IR, 2);
    // second start is from Reset; tie tdo high so a partial capture exists when reset hits
    tdo_tied = 1'b1;
    test_reset_mid_scan(TAP_SHIFT_DR, 3);
    tdo_tied = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
